// File: rtl/flac_pkg.sv
// Shared definitions for the Rice residual encoder.
// Holds the FSM encoding, chunk width and Rice parameter limit.
package flac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UNARY = 2'd1,
        TAIL  = 2'd2
    } state_t;

    localparam int CHUNK_W = 16;
    localparam int K_MAX   = 14;
    localparam int ACC_W   = 64;
    localparam int FILL_W  = 7;
    localparam int LEN_W   = 6;

    function automatic logic [3:0] sat_k(input logic [3:0] k);
        return (k > 4'(K_MAX)) ? 4'(K_MAX) : k;
    endfunction

endpackage

// File: rtl/rice_stream_encoder_if.sv
// Output word stream of the encoder: word, valid and ready.
interface rice_stream_encoder_if #(parameter int WORD_W = 32);

    logic [WORD_W-1:0] word;
    logic              valid;
    logic              ready;

    modport master (output word, output valid, input ready);
    modport slave  (input word, input valid, output ready);

endinterface

// File: rtl/bit_packer.sv
// 64-bit MSB-first bit accumulator with word read-out handshake.
// Chunks arrive right-aligned; padding rounds the fill up to a word.
module bit_packer
    import flac_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [LEN_W-1:0]      len,
    input  logic [31:0]           data,
    input  logic                  pad,
    output logic [FILL_W-1:0]     fill,
    rice_stream_encoder_if.master wif
);

    logic [ACC_W-1:0]  acc;
    logic              rd;
    logic [FILL_W-1:0] fill_rd;
    logic [FILL_W-1:0] sh;
    logic [FILL_W-1:0] pad_len;

    assign wif.valid = (fill >= FILL_W'(WORD_W));
    assign wif.word  = acc[ACC_W-1 -: WORD_W];
    assign rd        = wif.valid && wif.ready;

    always_comb begin
        fill_rd = rd ? fill - FILL_W'(WORD_W) : fill;
        sh      = FILL_W'(ACC_W) - fill_rd - FILL_W'(len);
        pad_len = FILL_W'((WORD_W - (int'(fill_rd) % WORD_W)) % WORD_W);
    end

    // New bits land directly below the surviving bits after any read shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc <= (rd ? (acc << WORD_W) : acc)
                 | (wr ? (ACC_W'(data) << sh) : '0);
            if (wr) begin
                fill <= fill_rd + FILL_W'(len);
            end else if (pad) begin
                fill <= fill_rd + pad_len;
            end else begin
                fill <= fill_rd;
            end
        end
    end

endmodule

// File: rtl/rice_stream_encoder.sv
// Rice encoder: zigzag-maps residuals and emits unary/binary codes
// in 16-bit unary chunks plus one tail chunk into a word packer.
module rice_stream_encoder
    import flac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WORD_W = 32
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iResidual,
    input  logic [3:0]        iRiceParam,
    input  logic              iFlush,
    output logic              oReady,
    output logic [WORD_W-1:0] oWord,
    output logic              oWordValid,
    input  logic              iWordReady,
    output logic              oFlushDone,
    output logic [31:0]       oBitCount
);

    state_t            state;
    logic [DATA_W-1:0] zeros;
    logic [3:0]        k;
    logic [K_MAX-1:0]  rem;
    logic              pend;

    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] mask;
    logic [3:0]        k_in;
    logic              accept;
    logic [LEN_W-1:0]  len;
    logic [31:0]       data;
    logic              fits;
    logic              wr;
    logic              pad;
    logic [FILL_W-1:0] fill;

    rice_stream_encoder_if #(.WORD_W(WORD_W)) wif ();

    assign oWord      = wif.word;
    assign oWordValid = wif.valid;
    assign wif.ready  = iWordReady;

    assign oReady = (state == IDLE) && !pend;
    assign accept = iValid && oReady;

    always_comb begin
        u    = {iResidual[DATA_W-2:0], 1'b0}
             ^ {DATA_W{iResidual[DATA_W-1]}};
        k_in = sat_k(iRiceParam);
        mask = (DATA_W'(1) << k_in) - DATA_W'(1);
        if (state == UNARY) begin
            len  = LEN_W'(CHUNK_W);
            data = '0;
        end else begin
            len  = LEN_W'(zeros) + LEN_W'(k) + LEN_W'(1);
            data = 32'(rem) | (32'd1 << k);
        end
        fits = ({1'b0, fill} + {2'b0, len}) <= 8'(ACC_W);
        wr   = (state != IDLE) && fits;
        pad  = (state == IDLE) && pend && (fill != '0);
    end

    bit_packer #(.WORD_W(WORD_W)) u_packer (
        .clk  (iClock),
        .rst  (iReset),
        .wr   (wr),
        .len  (len),
        .data (data),
        .pad  (pad),
        .fill (fill),
        .wif  (wif.master)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            zeros      <= '0;
            k          <= '0;
            rem        <= '0;
            pend       <= 1'b0;
            oFlushDone <= 1'b0;
            oBitCount  <= '0;
        end else begin
            oFlushDone <= 1'b0;
            if (wr) begin
                oBitCount <= oBitCount + 32'(len);
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        zeros <= u >> k_in;
                        k     <= k_in;
                        rem   <= K_MAX'(u & mask);
                        pend  <= iFlush;
                        if ((u >> k_in) >= DATA_W'(CHUNK_W)) begin
                            state <= UNARY;
                        end else begin
                            state <= TAIL;
                        end
                    end else if (iFlush && oReady) begin
                        pend <= 1'b1;
                    end else if (pend && fill == '0) begin
                        oFlushDone <= 1'b1;
                        pend       <= 1'b0;
                    end
                end
                UNARY: begin
                    if (wr) begin
                        zeros <= zeros - DATA_W'(CHUNK_W);
                        if (zeros < DATA_W'(2 * CHUNK_W)) begin
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (wr) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
